// File: rtl/nios_sd_loader_event_capture_if.sv
// Bundle of event-capture signals between the request/ack side and the capture block.
//   raw_req : N asynchronous request lines (may glitch/bounce)
//   ack     : N acknowledge lines from the CPU output PIO, synchronous to clk
//   pending : N sticky event flags (to PIO in_port)
//   overrun : N sticky "event while already pending" flags
//   level   : N debounced, polarity-corrected line levels
//   irq     : OR of pending, registered
// master drives requests/acks; slave is the capture block.
interface nios_sd_loader_event_capture_if #(
   parameter int N = 4
);
   logic [N-1:0] raw_req;
   logic [N-1:0] ack;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;
   logic [N-1:0] level;
   logic         irq;

   modport master (
      output raw_req, ack,
      input  pending, overrun, level, irq
   );

   modport slave (
      input  raw_req, ack,
      output pending, overrun, level, irq
   );
endinterface

// File: rtl/nios_sd_loader_event_capture.sv
// Event capture for the Nios SD loader status PIO.
// Each channel: polarity fix, 2-FF synchroniser, debounce, rising-edge detect,
// sticky pending flag and overrun flag; flags are cleared by a rising ack.
// Ports:
//   clk     : system clock (same domain as Nios CPU and PIOs)
//   reset_n : asynchronous active-low reset
//   bus     : slave modport of nios_sd_loader_event_capture_if
//             (raw_req/ack in; pending/overrun/level/irq out, all registered)

// One channel of the capture pipeline.
module nios_sd_loader_event_lane #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic ack,
   output logic pending,
   output logic overrun,
   output logic level,
   output logic pending_nxt
);
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2, ack_d;
   logic [CW-1:0] cnt;
   logic          accept, rise, ack_rise, overrun_nxt;

   // The line has disagreed with level for DEBOUNCE_CYCLES consecutive samples.
   assign accept   = (sync2 != level) && (cnt == CNT_LAST);
   assign rise     = accept & sync2;
   assign ack_rise = ack & ~ack_d;

   // A rise wins over a simultaneous ack so the new event is never lost.
   assign pending_nxt = rise | (pending & ~ack_rise);
   // Overrun only when the previous event is still outstanding (not being acked now).
   assign overrun_nxt = (rise & pending & ~ack_rise) | (overrun & ~ack_rise);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         ack_d   <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         sync1   <= raw ^ INVERT;
         sync2   <= sync1;
         ack_d   <= ack;
         pending <= pending_nxt;
         overrun <= overrun_nxt;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module nios_sd_loader_event_capture #(
   parameter int           N               = 4,
   parameter int           DEBOUNCE_CYCLES = 16,
   parameter logic [N-1:0] INVERT_MASK     = '0
) (
   input logic                           clk,
   input logic                           reset_n,
   nios_sd_loader_event_capture_if.slave bus
);
   logic [N-1:0] pending_v, overrun_v, level_v, pending_nxt;
   logic         irq_q;

   for (genvar i = 0; i < N; i++) begin : g_lane
      nios_sd_loader_event_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INVERT          (INVERT_MASK[i])
      ) u_lane (
         .clk         (clk),
         .reset_n     (reset_n),
         .raw         (bus.raw_req[i]),
         .ack         (bus.ack[i]),
         .pending     (pending_v[i]),
         .overrun     (overrun_v[i]),
         .level       (level_v[i]),
         .pending_nxt (pending_nxt[i])
      );
   end

   // Built from next-state so irq rises on the same edge as pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= 1'b0;
      else          irq_q <= |pending_nxt;
   end

   assign bus.pending = pending_v;
   assign bus.overrun = overrun_v;
   assign bus.level   = level_v;
   assign bus.irq     = irq_q;
endmodule

// File: tb/tb_nios_sd_loader_event_capture.sv
// Self-checking bench for nios_sd_loader_event_capture.
// Main DUT: N=4, DEBOUNCE_CYCLES=16, INVERT_MASK=0, checked by directed tasks
// and a random run against a run-length reference model.
// Second DUT: INVERT_MASK=4'b0001 with raw_req held low.
module tb_nios_sd_loader_event_capture;
   localparam int         D    = 16;
   localparam logic [3:0] MASK = 4'b0000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nios_sd_loader_event_capture_if #(.N(4)) bus ();
   nios_sd_loader_event_capture_if #(.N(4)) bus2 ();

   nios_sd_loader_event_capture #(.N(4), .DEBOUNCE_CYCLES(D), .INVERT_MASK(MASK)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   nios_sd_loader_event_capture #(.N(4), .DEBOUNCE_CYCLES(D), .INVERT_MASK(4'b0001)) dut_inv (
      .clk(clk), .reset_n(reset_n), .bus(bus2));

   // Reference model: a level change is accepted once the synchronised line
   // (input delayed by two samples) has held its new value for D samples.
   typedef struct packed {
      bit [3:0]      d1, d2, level, pend, ovr, ackd, last;
      bit [3:0][7:0] run;
      bit            irq;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t cur, logic [3:0] req, logic [3:0] ack);
      model_t n = cur;
      for (int c = 0; c < 4; c++) begin
         bit s, acc, rise, ar;
         s = cur.d2[c];
         if (s == cur.last[c]) begin
            if (cur.run[c] < 8'(D)) n.run[c] = cur.run[c] + 8'd1;
         end else begin
            n.run[c]  = 8'd1;
            n.last[c] = s;
         end
         acc  = (n.run[c] >= 8'(D)) && (s != cur.level[c]);
         rise = acc && s;
         ar   = ack[c] && !cur.ackd[c];
         if (acc) n.level[c] = s;
         n.pend[c] = rise ? 1'b1 : (ar ? 1'b0 : cur.pend[c]);
         n.ovr[c]  = (rise && cur.pend[c] && !ar) ? 1'b1 : (ar ? 1'b0 : cur.ovr[c]);
      end
      n.irq  = |n.pend;
      n.d2   = cur.d1;
      n.d1   = req ^ MASK;
      n.ackd = ack;
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= '0;
      else          m <= model_next(m, bus.raw_req, bus.ack);
   end

   task automatic test_reset();
      bus.raw_req = '0; bus.ack = '0;
      bus2.raw_req = '0; bus2.ack = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.pending, bus.overrun, bus.level, bus.irq} !== 13'd0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: got p=%b o=%b l=%b irq=%b expected all 0",
                     i, bus.pending, bus.overrun, bus.level, bus.irq);
         end
         // Inverted channel 0 held low at release: pending on edge 18 after release.
         checks++;
         if (bus2.pending !== ((i >= 17) ? 4'b0001 : 4'b0000)) begin
            failures++;
            $display("FAIL inv_release cycle %0d: got pending=%b expected %b",
                     i, bus2.pending, (i >= 17) ? 4'b0001 : 4'b0000);
         end
      end
   endtask

   task automatic test_latency();
      bus.raw_req[0] = 1'b1;
      for (int i = 0; i <= 17; i++) begin
         @(negedge clk);
         checks++;
         if (bus.pending[0] !== (i == 17) || bus.irq !== (i == 17)) begin
            failures++;
            $display("FAIL latency edge k+%0d: got pending0=%b irq=%b expected %b",
                     i, bus.pending[0], bus.irq, (i == 17));
         end
      end
   endtask

   task automatic test_bounce();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 12; i++) begin
            bus.raw_req[1] = (i < 10);
            @(negedge clk);
            checks++;
            if (bus.pending[1] !== 1'b0 || bus.level[1] !== 1'b0) begin
               failures++;
               $display("FAIL bounce pulse %0d cycle %0d: got pending1=%b level1=%b expected 0 0",
                        p, i, bus.pending[1], bus.level[1]);
            end
         end
      end
      repeat (20) @(negedge clk);
      checks++;
      if (bus.pending[1] !== 1'b0 || bus.level[1] !== 1'b0) begin
         failures++;
         $display("FAIL bounce_settle: got pending1=%b level1=%b expected 0 0",
                  bus.pending[1], bus.level[1]);
      end
   endtask

   task automatic test_ack_held();
      bus.raw_req[2] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.pending[2] !== 1'b1) begin
         failures++;
         $display("FAIL ack_setup: got pending2=%b expected 1", bus.pending[2]);
      end
      bus.raw_req[2] = 1'b0;
      repeat (20) @(negedge clk);
      bus.ack[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.pending[2] !== 1'b0) begin
         failures++;
         $display("FAIL ack_clear: got pending2=%b expected 0", bus.pending[2]);
      end
      bus.raw_req[2] = 1'b1;
      repeat (19) @(negedge clk);
      checks++;
      if (bus.pending[2] !== 1'b1 || bus.overrun[2] !== 1'b0) begin
         failures++;
         $display("FAIL ack_held_event: got pending2=%b overrun2=%b expected 1 0",
                  bus.pending[2], bus.overrun[2]);
      end
      bus.ack[2] = 1'b0;
      bus.raw_req[2] = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.pending[2] !== 1'b1) begin
         failures++;
         $display("FAIL ack_fall_hold: got pending2=%b expected 1", bus.pending[2]);
      end
      bus.ack[2] = 1'b1;
      @(negedge clk);
      bus.ack[2] = 1'b0;
      checks++;
      if (bus.pending[2] !== 1'b0) begin
         failures++;
         $display("FAIL ack_pulse_clear: got pending2=%b expected 0", bus.pending[2]);
      end
   endtask

   task automatic test_overrun();
      bus.raw_req[3] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.pending[3] !== 1'b1 || bus.overrun[3] !== 1'b0) begin
         failures++;
         $display("FAIL overrun_first: got pending3=%b overrun3=%b expected 1 0",
                  bus.pending[3], bus.overrun[3]);
      end
      bus.raw_req[3] = 1'b0;
      repeat (20) @(negedge clk);
      bus.raw_req[3] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.pending[3] !== 1'b1 || bus.overrun[3] !== 1'b1) begin
         failures++;
         $display("FAIL overrun_second: got pending3=%b overrun3=%b expected 1 1",
                  bus.pending[3], bus.overrun[3]);
      end
      bus.ack[3] = 1'b1;
      @(negedge clk);
      bus.ack[3] = 1'b0;
      checks++;
      if (bus.pending[3] !== 1'b0 || bus.overrun[3] !== 1'b0) begin
         failures++;
         $display("FAIL overrun_ack: got pending3=%b overrun3=%b expected 0 0",
                  bus.pending[3], bus.overrun[3]);
      end
      bus.raw_req[3] = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      // pending[0] is still set from the latency test.
      bus.raw_req[0] = 1'b0;
      repeat (20) @(negedge clk);
      bus.raw_req[0] = 1'b1;
      repeat (17) @(negedge clk);
      bus.ack[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.pending[0] !== 1'b1 || bus.overrun[0] !== 1'b0 || bus.level[0] !== 1'b1) begin
         failures++;
         $display("FAIL rise_with_ack: got pending0=%b overrun0=%b level0=%b expected 1 0 1",
                  bus.pending[0], bus.overrun[0], bus.level[0]);
      end
      bus.ack[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.pending[0] !== 1'b1) begin
         failures++;
         $display("FAIL rise_with_ack_hold: got pending0=%b expected 1", bus.pending[0]);
      end
   endtask

   task automatic test_reset_mid();
      bus.raw_req = 4'b0010;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.pending, bus.overrun, bus.level, bus.irq} !== 13'd0) begin
         failures++;
         $display("FAIL async_reset: got p=%b o=%b l=%b irq=%b expected all 0",
                  bus.pending, bus.overrun, bus.level, bus.irq);
      end
      @(negedge clk);
      bus.raw_req = '0;
      bus.ack = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (bus.pending !== 4'b0 || bus.level !== 4'b0) begin
         failures++;
         $display("FAIL reset_mid_debounce: got pending=%b level=%b expected 0 0",
                  bus.pending, bus.level);
      end
   endtask

   task automatic test_random();
      int hold [4];
      for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 40);
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         checks++;
         if (bus.pending !== m.pend || bus.overrun !== m.ovr ||
             bus.level !== m.level || bus.irq !== m.irq) begin
            failures++;
            $display("FAIL random cycle %0d: got p=%b o=%b l=%b irq=%b expected p=%b o=%b l=%b irq=%b",
                     cyc, bus.pending, bus.overrun, bus.level, bus.irq,
                     m.pend, m.ovr, m.level, m.irq);
         end
         for (int c = 0; c < 4; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               bus.raw_req[c] = ~bus.raw_req[c];
               hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 45);
            end
            if ($urandom_range(0, 9) == 0) bus.ack[c] = ~bus.ack[c];
         end
      end
      bus.raw_req = '0;
      bus.ack = '0;
   endtask

   task automatic test_invert();
      checks++;
      if (bus2.pending !== 4'b0001 || bus2.level !== 4'b0001 || bus2.irq !== 1'b1) begin
         failures++;
         $display("FAIL invert_held_low: got pending=%b level=%b irq=%b expected 0001 0001 1",
                  bus2.pending, bus2.level, bus2.irq);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_bounce();
      test_ack_held();
      test_overrun();
      test_simultaneous();
      test_reset_mid();
      test_random();
      test_invert();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
